// File: rtl/tt_ctrl_seq_pkg.sv
// Shared types and default timing for the TinyTapeout mux control sequencer.
package tt_ctrl_seq_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_T_ENA_OFF = 2;
    localparam int DEF_T_RST     = 4;
    localparam int DEF_P_HI      = 2;
    localparam int DEF_P_LO      = 2;
    localparam int DEF_T_SETTLE  = 8;

    // Phase timer width; every programmed duration fits in 1..15.
    localparam int TIMER_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIS,
        ST_RST,
        ST_LO,
        ST_HI,
        ST_SETTLE,
        ST_ENA
    } state_e;

    // The timer counts down to zero and the phase ends in the zero cycle,
    // so a phase of N cycles loads N-1.
    function automatic logic [TIMER_W-1:0] dur_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/tt_ctrl_seq_if.sv
// Request handshake between a host and the control sequencer.
interface tt_ctrl_seq_if
    import tt_ctrl_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ena;
    logic              req_force_rst;

    modport master (
        output req_valid,
        output req_addr,
        output req_ena,
        output req_force_rst,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_ena,
        input  req_force_rst,
        output req_ready
    );
endinterface

// File: rtl/tt_ctrl_seq_timer.sv
// Loadable 4-bit down-counter shared by every timed phase of the sequencer.
module tt_ctrl_seq_timer
    import tt_ctrl_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;

    // Load has priority; otherwise count down and park at zero.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/tt_ctrl_seq.sv
// Sequences the mux design-select ripple counter: disable, optional counter
// reset, forward increment pulses, settle, then enable the selected design.
module tt_ctrl_seq
    import tt_ctrl_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int T_ENA_OFF = DEF_T_ENA_OFF,
    parameter int T_RST     = DEF_T_RST,
    parameter int P_HI      = DEF_P_HI,
    parameter int P_LO      = DEF_P_LO,
    parameter int T_SETTLE  = DEF_T_SETTLE
) (
    input  logic              clk,
    input  logic              rst_n,
    tt_ctrl_seq_if.slave      req,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              done
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pcnt_q, pcnt_d;       // increment pulses still to issue
    logic [ADDR_W-1:0]  addr_q, addr_d;       // captured target address
    logic               ena_q, ena_d;         // captured enable value
    logic               run_rst_q, run_rst_d; // request needs a counter reset

    logic               sel_rst_n_q, sel_rst_n_d;
    logic               inc_q, inc_d;
    logic               ctrl_ena_q, ctrl_ena_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic               cur_valid_q, cur_valid_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_zero;
    logic               pulses_left;

    tt_ctrl_seq_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign pulses_left = (pcnt_q != '0);

    // Next-state, phase timer loads and registered-output next values.
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        addr_d    = addr_q;
        ena_d     = ena_q;
        run_rst_d = run_rst_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req.req_valid && ready_q) begin
                    addr_d    = req.req_addr;
                    ena_d     = req.req_ena;
                    run_rst_d = req.req_force_rst || !cur_valid_q;
                    // After a counter reset the counter sits at 0, so the
                    // pulse count is the target itself; otherwise count
                    // forward from the known address, wrapping.
                    pcnt_d    = (req.req_force_rst || !cur_valid_q)
                                ? req.req_addr
                                : req.req_addr - cur_addr_q;
                    state_d   = ST_DIS;
                    tmr_load  = 1'b1;
                    tmr_val   = dur_load(T_ENA_OFF);
                end
            end
            ST_DIS: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (run_rst_q) begin
                        state_d = ST_RST;
                        tmr_val = dur_load(T_RST);
                    end else if (pulses_left) begin
                        state_d = ST_LO;
                        tmr_val = dur_load(P_LO);
                    end else begin
                        state_d = ST_SETTLE;
                        tmr_val = dur_load(T_SETTLE);
                    end
                end
            end
            ST_RST: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (pulses_left) begin
                        state_d = ST_LO;
                        tmr_val = dur_load(P_LO);
                    end else begin
                        state_d = ST_SETTLE;
                        tmr_val = dur_load(T_SETTLE);
                    end
                end
            end
            ST_LO: begin
                if (tmr_zero) begin
                    state_d  = ST_HI;
                    pcnt_d   = pcnt_q - ADDR_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = dur_load(P_HI);
                end
            end
            ST_HI: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (pulses_left) begin
                        state_d = ST_LO;
                        tmr_val = dur_load(P_LO);
                    end else begin
                        state_d = ST_SETTLE;
                        tmr_val = dur_load(T_SETTLE);
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_ENA;
                end
            end
            ST_ENA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so each one changes
        // exactly on the edge that enters the phase it belongs to.
        cur_addr_d  = (state_d == ST_ENA) ? addr_q : cur_addr_q;
        cur_valid_d = (state_d == ST_ENA) ? 1'b1   : cur_valid_q;
        sel_rst_n_d = !((state_d == ST_RST) ||
                        ((state_d == ST_IDLE) && !cur_valid_d));
        inc_d       = (state_d == ST_HI);
        done_d      = (state_d == ST_ENA);
        ready_d     = (state_d == ST_IDLE);
        if (state_d == ST_ENA) begin
            ctrl_ena_d = ena_q;
        end else if (state_d == ST_IDLE) begin
            ctrl_ena_d = ctrl_ena_q;
        end else begin
            ctrl_ena_d = 1'b0;
        end
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pcnt_q      <= '0;
            addr_q      <= '0;
            ena_q       <= 1'b0;
            run_rst_q   <= 1'b0;
            sel_rst_n_q <= 1'b0;
            inc_q       <= 1'b0;
            ctrl_ena_q  <= 1'b0;
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            addr_q      <= addr_d;
            ena_q       <= ena_d;
            run_rst_q   <= run_rst_d;
            sel_rst_n_q <= sel_rst_n_d;
            inc_q       <= inc_d;
            ctrl_ena_q  <= ctrl_ena_d;
            cur_addr_q  <= cur_addr_d;
            cur_valid_q <= cur_valid_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ctrl_ena_q;
    assign cur_addr       = cur_addr_q;
    assign cur_valid      = cur_valid_q;
    assign done           = done_q;
    assign req.req_ready  = ready_q;

endmodule
